msrv32_trap_controller: RTL and testbench

Machine-mode trap sequencer for the msrv32 RV32I core. Sits between the decode/execute stage and the CSR file, watching decoded exception/return indications and the interrupt enable/pending bits. It drives the CSR file's trap-control strobes (set_epc, set_cause, cause, i_or_e, mie_clear/mie_set, instret_inc), and the PC-source select and pipeline flush. It owns the RESET / OPERATING / TRAP_TAKEN / TRAP_RETURN state machine.

---
 rtl/msrv32_pkg.sv | 36 +++
 rtl/msrv32_trap_prioritizer.sv | 62 ++++++
 rtl/msrv32_trap_controller.sv | 140 ++++++++++++++
 tb/tb_msrv32_trap_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: trap-controller state encoding, PC-source selects,
// and machine-mode exception/interrupt cause codes.
package msrv32_pkg;

    typedef logic [2:0] msrv32_state_t;

    localparam msrv32_state_t STATE_RESET       = 3'd0;
    localparam msrv32_state_t STATE_OPERATING   = 3'd1;
    localparam msrv32_state_t STATE_TRAP_TAKEN  = 3'd2;
    localparam msrv32_state_t STATE_TRAP_RETURN = 3'd3;
    localparam msrv32_state_t STATE_WAIT        = 3'd4;

    localparam logic [1:0] PC_SRC_BOOT = 2'd0;
    localparam logic [1:0] PC_SRC_NEXT = 2'd1;
    localparam logic [1:0] PC_SRC_TRAP = 2'd2;
    localparam logic [1:0] PC_SRC_EPC  = 2'd3;

    localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    localparam logic [3:0] MSI = 4'd3;
    localparam logic [3:0] MTI = 4'd7;
    localparam logic [3:0] MEI = 4'd11;

    // Exception codes that the CSR file handles with a misaligned-address capture.
    function automatic logic is_misaligned_cause(input logic [3:0] cause);
        return (cause == CAUSE_MISALIGNED_INSTR) ||
               (cause == CAUSE_MISALIGNED_LOAD)  ||
               (cause == CAUSE_MISALIGNED_STORE);
    endfunction

endpackage

// File: rtl/msrv32_trap_prioritizer.sv
// Combinational trap arbiter: picks the single highest-priority pending
// interrupt or exception and reports its cause code.
module msrv32_trap_prioritizer
    import msrv32_pkg::*;
(
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    output logic       trap_valid_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out
);

    logic ext_irq;
    logic sw_irq;
    logic tmr_irq;
    logic irq_pending;
    logic exc_pending;

    assign ext_irq     = meie_in & meip_in;
    assign sw_irq      = msie_in & msip_in;
    assign tmr_irq     = mtie_in & mtip_in;
    assign irq_pending = mie_in & (ext_irq | sw_irq | tmr_irq);
    assign exc_pending = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                         misaligned_store_in | ecall_in | ebreak_in;

    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    always_comb begin
        trap_valid_out = irq_pending | exc_pending;
        i_or_e_out     = 1'b0;
        cause_out      = 4'd0;
        if (irq_pending) begin
            i_or_e_out = 1'b1;
            if (ext_irq)     cause_out = MEI;
            else if (sw_irq) cause_out = MSI;
            else             cause_out = MTI;
        end else if (misaligned_instr_in) begin
            cause_out = CAUSE_MISALIGNED_INSTR;
        end else if (illegal_instr_in) begin
            cause_out = CAUSE_ILLEGAL;
        end else if (ebreak_in) begin
            cause_out = CAUSE_BREAKPOINT;
        end else if (ecall_in) begin
            cause_out = CAUSE_ECALL_M;
        end else if (misaligned_load_in) begin
            cause_out = CAUSE_MISALIGNED_LOAD;
        end else if (misaligned_store_in) begin
            cause_out = CAUSE_MISALIGNED_STORE;
        end
    end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer for the msrv32 core. Define MSRV32_WFI_EN to add
// the WAIT state that stalls the pipeline on wfi until an enabled interrupt pends.
module msrv32_trap_controller
    import msrv32_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       wfi_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       i_or_e_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic [3:0] cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out,
    output logic       flush_out,
    output logic       stall_out,
    output logic [1:0] pc_src_out
);

    msrv32_state_t state_q;
    msrv32_state_t state_d;

    logic       trap_valid;
    logic       trap_is_irq;
    logic [3:0] trap_cause;

    msrv32_trap_prioritizer u_prioritizer (
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .mtie_in             (mtie_in),
        .msie_in             (msie_in),
        .meip_in             (meip_in),
        .mtip_in             (mtip_in),
        .msip_in             (msip_in),
        .illegal_instr_in    (illegal_instr_in),
        .misaligned_instr_in (misaligned_instr_in),
        .misaligned_load_in  (misaligned_load_in),
        .misaligned_store_in (misaligned_store_in),
        .ecall_in            (ecall_in),
        .ebreak_in           (ebreak_in),
        .trap_valid_out      (trap_valid),
        .i_or_e_out          (trap_is_irq),
        .cause_out           (trap_cause)
    );

`ifdef MSRV32_WFI_EN
    // Wake-up ignores the global enable; the trap itself still honours it.
    logic wake;
    assign wake = (meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in);
`endif

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= STATE_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d                  = state_q;
        pc_src_out               = PC_SRC_BOOT;
        flush_out                = 1'b0;
        stall_out                = 1'b0;
        set_epc_out              = 1'b0;
        set_cause_out            = 1'b0;
        cause_out                = 4'd0;
        i_or_e_out               = 1'b0;
        mie_clear_out            = 1'b0;
        mie_set_out              = 1'b0;
        instret_inc_out          = 1'b0;
        misaligned_exception_out = 1'b0;

        case (state_q)
            STATE_RESET: begin
                state_d = STATE_OPERATING;
            end
            STATE_OPERATING: begin
                pc_src_out = PC_SRC_NEXT;
                if (trap_valid) begin
                    set_epc_out              = 1'b1;
                    set_cause_out            = 1'b1;
                    mie_clear_out            = 1'b1;
                    flush_out                = 1'b1;
                    cause_out                = trap_cause;
                    i_or_e_out               = trap_is_irq;
                    misaligned_exception_out = !trap_is_irq && is_misaligned_cause(trap_cause);
                    state_d                  = STATE_TRAP_TAKEN;
                end else if (mret_in) begin
                    mie_set_out     = 1'b1;
                    instret_inc_out = 1'b1;
                    flush_out       = 1'b1;
                    state_d         = STATE_TRAP_RETURN;
                end else if (wfi_in) begin
                    instret_inc_out = 1'b1;
`ifdef MSRV32_WFI_EN
                    state_d         = STATE_WAIT;
`endif
                end else begin
                    instret_inc_out = 1'b1;
                end
            end
            STATE_TRAP_TAKEN: begin
                pc_src_out = PC_SRC_TRAP;
                flush_out  = 1'b1;
                state_d    = STATE_OPERATING;
            end
            STATE_TRAP_RETURN: begin
                pc_src_out = PC_SRC_EPC;
                flush_out  = 1'b1;
                state_d    = STATE_OPERATING;
            end
`ifdef MSRV32_WFI_EN
            STATE_WAIT: begin
                pc_src_out = PC_SRC_NEXT;
                stall_out  = 1'b1;
                if (wake) state_d = STATE_OPERATING;
            end
`endif
            default: begin
                state_d = STATE_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Self-checking bench for msrv32_trap_controller: a phase-level reference model
// checked every cycle, plus directed vectors with hand-computed expectations.
module tb_msrv32_trap_controller;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic illegal_instr_in = 1'b0, misaligned_instr_in = 1'b0;
    logic misaligned_load_in = 1'b0, misaligned_store_in = 1'b0;
    logic ecall_in = 1'b0, ebreak_in = 1'b0, mret_in = 1'b0, wfi_in = 1'b0;
    logic mie_in = 1'b0, meie_in = 1'b0, mtie_in = 1'b0, msie_in = 1'b0;
    logic meip_in = 1'b0, mtip_in = 1'b0, msip_in = 1'b0;

    logic       i_or_e_out, set_cause_out, set_epc_out;
    logic [3:0] cause_out;
    logic       mie_clear_out, mie_set_out, instret_inc_out;
    logic       misaligned_exception_out, flush_out, stall_out;
    logic [1:0] pc_src_out;

    msrv32_trap_controller dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .illegal_instr_in         (illegal_instr_in),
        .misaligned_instr_in      (misaligned_instr_in),
        .misaligned_load_in       (misaligned_load_in),
        .misaligned_store_in      (misaligned_store_in),
        .ecall_in                 (ecall_in),
        .ebreak_in                (ebreak_in),
        .mret_in                  (mret_in),
        .wfi_in                   (wfi_in),
        .mie_in                   (mie_in),
        .meie_in                  (meie_in),
        .mtie_in                  (mtie_in),
        .msie_in                  (msie_in),
        .meip_in                  (meip_in),
        .mtip_in                  (mtip_in),
        .msip_in                  (msip_in),
        .i_or_e_out               (i_or_e_out),
        .set_cause_out            (set_cause_out),
        .set_epc_out              (set_epc_out),
        .cause_out                (cause_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .instret_inc_out          (instret_inc_out),
        .misaligned_exception_out (misaligned_exception_out),
        .flush_out                (flush_out),
        .stall_out                (stall_out),
        .pc_src_out               (pc_src_out)
    );

    always #5 clk_in = ~clk_in;

`ifdef MSRV32_WFI_EN
    localparam bit WFI_EN = 1'b1;
`else
    localparam bit WFI_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model phases: 0 reset, 1 running, 2 jumping to mtvec, 3 returning to epc, 4 waiting.
    int phase = 0;

    function automatic void resolve(output bit valid, output bit irq, output int code);
        bit hit_i[3];
        int code_i[3];
        bit hit_e[6];
        int code_e[6];
        hit_i  = '{meie_in && meip_in, msie_in && msip_in, mtie_in && mtip_in};
        code_i = '{11, 3, 7};
        hit_e  = '{misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
                   misaligned_load_in, misaligned_store_in};
        code_e = '{0, 2, 3, 11, 4, 6};
        valid = 1'b0;
        irq   = 1'b0;
        code  = 0;
        for (int i = 0; i < 3; i++)
            if (mie_in && hit_i[i] && !valid) begin valid = 1'b1; irq = 1'b1; code = code_i[i]; end
        for (int i = 0; i < 6; i++)
            if (hit_e[i] && !valid) begin valid = 1'b1; code = code_e[i]; end
    endfunction

    function automatic int next_phase(input int ph);
        bit v, irq;
        int code;
        bit wake;
        resolve(v, irq, code);
        wake = (meie_in && meip_in) || (msie_in && msip_in) || (mtie_in && mtip_in);
        case (ph)
            1: begin
                if (v)                    return 2;
                else if (mret_in)         return 3;
                else if (wfi_in && WFI_EN) return 4;
                else                      return 1;
            end
            4:       return wake ? 1 : 4;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) phase <= 0;
        else        phase <= next_phase(phase);
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk_in) begin : compare
        bit v, irq;
        int code;
        logic [1:0] e_pc;
        logic [3:0] e_cause;
        logic e_flush, e_stall, e_epc, e_setc, e_clr, e_set, e_inst, e_mis, e_ioe;
        e_pc = 0; e_cause = 0; e_flush = 0; e_stall = 0; e_epc = 0; e_setc = 0;
        e_clr = 0; e_set = 0; e_inst = 0; e_mis = 0; e_ioe = 0;
        if (!rst_in) begin
            case (phase)
                1: begin
                    e_pc = 1;
                    resolve(v, irq, code);
                    if (v) begin
                        e_epc = 1; e_setc = 1; e_clr = 1; e_flush = 1;
                        e_cause = 4'(code); e_ioe = irq;
                        e_mis = !irq && (code == 0 || code == 4 || code == 6);
                    end else if (mret_in) begin
                        e_set = 1; e_inst = 1; e_flush = 1;
                    end else begin
                        e_inst = 1;
                    end
                end
                2: begin e_pc = 2; e_flush = 1; end
                3: begin e_pc = 3; e_flush = 1; end
                4: begin e_pc = 1; e_stall = 1; end
                default: e_pc = 0;
            endcase
        end
        check("m_pc_src", pc_src_out, e_pc);
        check("m_flush", flush_out, e_flush);
        check("m_stall", stall_out, e_stall);
        check("m_set_epc", set_epc_out, e_epc);
        check("m_set_cause", set_cause_out, e_setc);
        check("m_cause", cause_out, e_cause);
        check("m_i_or_e", i_or_e_out, e_ioe);
        check("m_mie_clear", mie_clear_out, e_clr);
        check("m_mie_set", mie_set_out, e_set);
        check("m_instret", instret_inc_out, e_inst);
        check("m_misaligned", misaligned_exception_out, e_mis);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic clear_inputs();
        illegal_instr_in = 0; misaligned_instr_in = 0; misaligned_load_in = 0;
        misaligned_store_in = 0; ecall_in = 0; ebreak_in = 0; mret_in = 0; wfi_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0; meip_in = 0; mtip_in = 0; msip_in = 0;
    endtask

    // Exception priority table: {mis_instr, illegal, ebreak, ecall, mis_load, mis_store} -> cause.
    logic [5:0] exc_vec[6]   = '{6'b111111, 6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001};
    logic [3:0] exc_cause[6] = '{4'd0, 4'd2, 4'd3, 4'd11, 4'd4, 4'd6};
    logic       exc_mis[6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        clear_inputs();
        rst_in = 1;
        repeat (3) @(posedge clk_in);
        sample();
        check("reset_pc", pc_src_out, 0);
        check("reset_flush", flush_out, 0);

        tick(); rst_in = 0;
        sample(); check("boot_cycle_pc", pc_src_out, 0);
        tick();
        sample(); check("op_pc", pc_src_out, 1); check("op_instret", instret_inc_out, 1);

        tick(); illegal_instr_in = 1;
        sample();
        check("ill_set_cause", set_cause_out, 1); check("ill_set_epc", set_epc_out, 1);
        check("ill_cause", cause_out, 2); check("ill_i_or_e", i_or_e_out, 0);
        check("ill_mie_clear", mie_clear_out, 1); check("ill_instret", instret_inc_out, 0);
        tick(); clear_inputs();
        sample(); check("ill_next_pc", pc_src_out, 2); check("ill_next_set_epc", set_epc_out, 0);
        tick();
        sample(); check("ill_back_pc", pc_src_out, 1);

        tick(); mie_in = 1; meie_in = 1; meip_in = 1; ecall_in = 1;
        sample(); check("irq_vs_ecall_cause", cause_out, 11); check("irq_vs_ecall_i_or_e", i_or_e_out, 1);
        tick(); clear_inputs();
        sample(); check("irq_next_pc", pc_src_out, 2);
        tick();

        mret_in = 1;
        sample(); check("mret_mie_set", mie_set_out, 1); check("mret_instret", instret_inc_out, 1);
        tick(); clear_inputs();
        sample(); check("mret_next_pc", pc_src_out, 3);
        tick();
        sample(); check("mret_back_pc", pc_src_out, 1);

        tick(); misaligned_store_in = 1; mtie_in = 1; mtip_in = 1;
        sample(); check("store_cause", cause_out, 6); check("store_misaligned", misaligned_exception_out, 1);
        check("store_i_or_e", i_or_e_out, 0);
        tick(); clear_inputs(); tick();

        mret_in = 1; mie_in = 1; mtie_in = 1; mtip_in = 1;
        sample(); check("mret_irq_cause", cause_out, 7); check("mret_irq_mie_set", mie_set_out, 0);
        tick(); clear_inputs(); tick();

        for (int i = 0; i < 6; i++) begin
            {misaligned_instr_in, illegal_instr_in, ebreak_in, ecall_in,
             misaligned_load_in, misaligned_store_in} = exc_vec[i];
            sample();
            check("exc_prio_cause", cause_out, exc_cause[i]);
            check("exc_prio_misaligned", misaligned_exception_out, exc_mis[i]);
            tick(); clear_inputs(); tick();
        end

        mie_in = 1; msie_in = 1; msip_in = 1; mtie_in = 1; mtip_in = 1;
        sample(); check("sw_over_timer", cause_out, 3);
        tick(); clear_inputs(); tick();

        ebreak_in = 1;
        sample(); check("held_first_cause", cause_out, 3);
        tick();
        sample(); check("held_taken_set_cause", set_cause_out, 0); check("held_taken_pc", pc_src_out, 2);
        tick();
        sample(); check("held_again_set_cause", set_cause_out, 1);
        tick(); clear_inputs();
        #1 check("mid_trap_pc", pc_src_out, 2);
        rst_in = 1;
        #1 check("rst_mid_trap_pc", pc_src_out, 0); check("rst_mid_trap_flush", flush_out, 0);
        tick(); rst_in = 0;
        tick();
        sample(); check("after_rst_pc", pc_src_out, 1);

        tick(); illegal_instr_in = 1;
        #1 check("pre_rst_set_epc", set_epc_out, 1);
        rst_in = 1;
        #1 check("rst_detect_set_epc", set_epc_out, 0);
        clear_inputs();
        tick(); rst_in = 0;
        tick();

`ifdef MSRV32_WFI_EN
        wfi_in = 1;
        sample(); check("wfi_entry_instret", instret_inc_out, 1); check("wfi_entry_stall", stall_out, 0);
        tick(); wfi_in = 0;
        for (int i = 0; i < 5; i++) begin
            sample(); check("wait_stall", stall_out, 1); check("wait_pc", pc_src_out, 1);
            tick();
        end
        mie_in = 1; msie_in = 1; msip_in = 1;
        sample(); check("wake_cycle_stall", stall_out, 1);
        tick();
        sample(); check("wake_trap_cause", cause_out, 3); check("wake_stall", stall_out, 0);
        check("wake_set_cause", set_cause_out, 1);
        tick(); clear_inputs(); tick();

        wfi_in = 1; tick(); wfi_in = 0;
        mtie_in = 1; mtip_in = 1;
        sample(); check("wake_nomie_wait", stall_out, 1);
        tick();
        sample(); check("wake_nomie_stall", stall_out, 0); check("wake_nomie_set_cause", set_cause_out, 0);
        tick(); clear_inputs();

        wfi_in = 1; tick(); wfi_in = 0;
        sample(); check("wait_before_rst", stall_out, 1);
        tick(); rst_in = 1;
        #1 check("rst_wait_stall", stall_out, 0); check("rst_wait_pc", pc_src_out, 0);
        tick(); rst_in = 0;
        tick();
`else
        wfi_in = 1;
        sample(); check("wfi_nop_instret", instret_inc_out, 1); check("wfi_nop_stall", stall_out, 0);
        check("wfi_nop_pc", pc_src_out, 1);
        tick();
        sample(); check("wfi_nop_next_pc", pc_src_out, 1); check("wfi_nop_next_stall", stall_out, 0);
        tick(); clear_inputs();
`endif

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
